// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters; each access takes MEM_LAT+2 cycles, request to IDLE.
// Requesters hold their request until their one-cycle done pulse; ties alternate with the previous owner.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_data,
    output logic              err_rw
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] latCnt;
    logic             opWrite;
    logic             dReq;
    logic             pickData;
    logic             grantNow;
    logic             lastBusy;

    always_comb begin
        dReq      = d_read | d_write;
        // Round-robin: on a tie the port that did not own the last access wins.
        pickData  = dReq & (~i_req | ~grant_data);
        grantNow  = (state == IDLE) & (i_req | dReq);
        lastBusy  = (state == BUSY) & (latCnt == LAST_CNT);
        stateNext = state;
        case (state)
            IDLE:    if (i_req | dReq) stateNext = BUSY;
            BUSY:    if (latCnt == LAST_CNT) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_data <= 1'b1;
            opWrite    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err_rw     <= 1'b0;
            latCnt     <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grantNow) begin
                grant_data <= pickData;
                // A simultaneous read+write executes as a write and flags the conflict.
                opWrite    <= pickData & d_write;
                mem_addr   <= pickData ? d_addr : i_addr;
                mem_wdata  <= pickData ? d_wdata : '0;
                if (pickData & d_read & d_write) begin
                    err_rw <= 1'b1;
                end
            end
            if (state == BUSY) begin
                latCnt <= latCnt + CNT_W'(1);
            end else begin
                latCnt <= '0;
            end
            if (lastBusy & ~opWrite) begin
                if (grant_data) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_read  = (state == BUSY) & ~opWrite;
    assign mem_write = (state == BUSY) & opWrite & (latCnt == '0);
    assign busy      = (state != IDLE);
    assign i_done    = (state == DONE) & ~grant_data;
    assign d_done    = (state == DONE) & grant_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters push expected completions/writes, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    typedef struct {
        logic [63:0] rd;
        int          cyc;
        int          reads;
        logic [63:0] addr;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        i_req, d_read, d_write;
    logic [63:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_read, mem_write, busy, grant_data, err_rw;
    logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        b_i_req, b_d_read, b_d_write;
    logic [63:0] b_i_addr, b_d_addr, b_d_wdata;
    logic        b_i_done, b_d_done, b_mem_read, b_mem_write, b_busy, b_grant_data, b_err_rw;
    logic [63:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   readCnt = 0;
    exp_t iQ[$];
    exp_t dQ[$];
    wr_t  wQ[$];

    function automatic logic [63:0] memModel(input logic [63:0] a);
        case (a)
            64'h40:  return 64'h0000_0000_00A0_0093;
            64'h80:  return 64'h0000_0000_1234_5678;
            64'h200: return 64'h0000_0000_CAFE_F00D;
            64'h8:   return 64'h0000_0000_0000_0BAD;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign mem_rdata   = mem_read   ? memModel(mem_addr)   : 64'h0;
    assign b_mem_rdata = b_mem_read ? memModel(b_mem_addr) : 64'h0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dutA (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .grant_data(grant_data), .err_rw(err_rw)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dutB (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_done(b_i_done), .i_rdata(b_i_rdata),
        .d_read(b_d_read), .d_write(b_d_write), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .grant_data(b_grant_data), .err_rw(b_err_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every completion and write strobe against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (reset) begin
            readCnt = 0;
        end else begin
            if (mem_read) readCnt++;
            if (mem_write) begin
                if (wQ.size() == 0) chk("spurious mem_write", mem_write, 0);
                else begin
                    w = wQ.pop_front();
                    chk("write addr", mem_addr, w.addr);
                    chk("write data", mem_wdata, w.data);
                    chk("write cycle", cyc, w.cyc);
                end
            end
            if (i_done && d_done) chk("both dones", d_done, 0);
            if (i_done) begin
                if (iQ.size() == 0) chk("spurious i_done", i_done, 0);
                else begin
                    e = iQ.pop_front();
                    chk("i_rdata", i_rdata, e.rd);
                    chk("i_done cycle", cyc, e.cyc);
                    chk("fetch read cycles", readCnt, e.reads);
                    chk("fetch mem_addr", mem_addr, e.addr);
                    chk("grant_data on i_done", grant_data, 0);
                end
                readCnt = 0;
            end
            if (d_done) begin
                if (dQ.size() == 0) chk("spurious d_done", d_done, 0);
                else begin
                    e = dQ.pop_front();
                    chk("d_rdata", d_rdata, e.rd);
                    chk("d_done cycle", cyc, e.cyc);
                    chk("data read cycles", readCnt, e.reads);
                    chk("data mem_addr", mem_addr, e.addr);
                    chk("grant_data on d_done", grant_data, 1);
                end
                readCnt = 0;
            end
        end
    end

    // One requester transaction: raise, expect done 'off' cycles later, drop on done.
    task automatic doReq(input bit isData, input bit rd, input bit wr, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] expRd, input int off);
        exp_t e;
        int   n;
        bit   got;
        @(posedge clk); #1;
        n       = cyc;
        e.rd    = expRd;
        e.cyc   = n + off;
        e.reads = (isData && wr) ? 0 : 2;
        e.addr  = addr;
        if (isData) begin
            d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
            dQ.push_back(e);
            if (wr) wQ.push_back('{addr, wdata, n + off - 2});
        end else begin
            i_req = 1'b1; i_addr = addr;
            iQ.push_back(e);
        end
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (isData ? d_done : i_done) begin
                got = 1'b1;
                break;
            end
        end
        if (isData) begin
            d_read = 1'b0; d_write = 1'b0;
        end else begin
            i_req = 1'b0;
        end
        chk(isData ? "d_done seen" : "i_done seen", got, 1);
    endtask

    initial begin
        int n, nd, d1, d2;
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, nd, d1, d2;
        reset = 1'b1;
        {i_req, d_read, d_write} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        {b_i_req, b_d_read, b_d_write} = '0;
        b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0;
        #12;
        chk("reset i_done", i_done, 0);
        chk("reset d_done", d_done, 0);
        chk("reset mem_read", mem_read, 0);
        chk("reset mem_write", mem_write, 0);
        chk("reset busy", busy, 0);
        chk("reset err_rw", err_rw, 0);
        chk("reset i_rdata", i_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset grant_data", grant_data, 1);
        chk("reset B grant_data", b_grant_data, 1);
        @(posedge clk); #1 reset = 1'b0;

        // Single fetch, then a store that must leave d_rdata alone.
        doReq(0, 0, 0, 64'h40, 64'h0, 64'h00A0_0093, 3);
        doReq(1, 0, 1, 64'h100, 64'hDEAD, 64'h0, 3);

        // Ties: fetch first, load after; grant ends on data; repeated tie goes to fetch again.
        fork
            doReq(0, 0, 0, 64'h80, 64'h0, 64'h1234_5678, 3);
            doReq(1, 1, 0, 64'h200, 64'h0, 64'hCAFE_F00D, 7);
        join
        #1 chk("grant_data after tie", grant_data, 1);
        fork
            doReq(0, 0, 0, 64'h40, 64'h0, 64'h00A0_0093, 3);
            doReq(1, 1, 0, 64'h8, 64'h0, 64'h0BAD, 7);
        join

        // Read+write conflict executes as a write and latches err_rw.
        doReq(1, 1, 1, 64'h8, 64'h55, 64'h0BAD, 3);
        #1 chk("err_rw set", err_rw, 1);
        doReq(0, 0, 0, 64'h40, 64'h0, 64'h00A0_0093, 3);
        #1 chk("err_rw sticky", err_rw, 1);

        // Request dropped and address changed after grant: access still completes at the original address.
        @(posedge clk); #1;
        n = cyc;
        i_req = 1'b1; i_addr = 64'h80;
        iQ.push_back('{64'h1234_5678, n + 3, 2, 64'h80});
        @(posedge clk); #1;
        i_req = 1'b0; i_addr = 64'h40;
        repeat (4) @(posedge clk);
        #1 chk("dropped fetch completed", iQ.size(), 0);

        // Reset in the second BUSY cycle of a load.
        @(posedge clk); #1;
        d_read = 1'b1; d_addr = 64'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mem_read before reset", mem_read, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort mem_read", mem_read, 0);
        chk("abort busy", busy, 0);
        chk("abort d_done", d_done, 0);
        chk("abort err_rw", err_rw, 0);
        chk("abort d_rdata", d_rdata, 0);
        chk("abort grant_data", grant_data, 1);
        d_read = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        fork
            doReq(0, 0, 0, 64'h40, 64'h0, 64'h00A0_0093, 3);
            doReq(1, 1, 0, 64'h80, 64'h0, 64'h1234_5678, 7);
        join

        // MEM_LAT=1 instance: load done two cycles after request; held request restarts after IDLE.
        @(posedge clk); #1;
        n = cyc; nd = 0; d1 = -1; d2 = -1;
        b_d_read = 1'b1; b_d_addr = 64'h200;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b_d_done) begin
                if (nd == 0) d1 = cyc;
                else d2 = cyc;
                nd++;
                if (nd == 2) b_d_read = 1'b0;
            end
        end
        b_d_read = 1'b0;
        chk("B done count", nd, 2);
        chk("B first done cycle", d1, n + 2);
        chk("B second done cycle", d2, n + 5);
        chk("B d_rdata", b_d_rdata, 64'hCAFE_F00D);
        chk("B i_done idle", b_i_done, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("fetch queue drained", iQ.size(), 0);
        chk("data queue drained", dQ.size(), 0);
        chk("write queue drained", wQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch path (IMemRead/IRWrite side) and the data path (DMemRead/DMemWrite side) of the multicycle core.
- Sits between the control FSM/datapath and the memory model.
- Sequences fixed-latency memory accesses, arbitrates round-robin on ties and returns a one-cycle done pulse with registered read data.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LAT, 2, memory read latency in cycles (>=1); data is valid MEM_LAT cycles after the address is presented with mem_read high.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- i_req  in  1  instruction fetch request; held until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_done  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DATA_W  fetched word; registered, held until next i_done
- d_read  in  1  data load request; held until d_done
- d_write  in  1  data store request; held until d_done
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  load data; registered, held until next load d_done
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in BUSY and DONE
- grant_data  out  1  current/last owner: 1 = data port, 0 = fetch port
- err_rw  out  1  sticky error: d_read and d_write were both sampled high at grant

Behaviour:
- Reset (async):
  - State goes to IDLE.
  - These outputs are forced to 0 immediately: i_done, d_done, mem_read, mem_write, busy, err_rw, lat counter, i_rdata, d_rdata, mem_addr, mem_wdata.
  - grant_data resets to 1, so the first tie goes to fetch.
- States:
  - IDLE -> BUSY when any request is high at the clock edge.
  - BUSY -> DONE when the counter reaches MEM_LAT-1.
  - DONE -> IDLE always.
- Arbitration (IDLE only):
  - Only one requester high: it wins.
  - Both high: the owner is the port opposite to the current grant_data (round-robin).
  - On grant, the arbiter latches owner, op (read/write), address and wdata into internal registers. mem_addr and mem_wdata drive from these registers and stay stable for the whole transaction.
- BUSY timing:
  - Counter starts at 0 and increments each cycle.
  - Read: mem_read is high for all MEM_LAT BUSY cycles. On the last BUSY cycle, mem_rdata is captured into i_rdata or d_rdata.
  - Write: mem_write is high only in the first BUSY cycle; the remaining BUSY cycles idle. Stores take the same MEM_LAT latency.
- DONE: exactly one cycle; the owner's done pulses. No arbitration happens in DONE.
- Latency: request high in IDLE at cycle 0 -> BUSY in cycles 1..MEM_LAT -> done in cycle MEM_LAT+1 -> IDLE at MEM_LAT+2. Back-to-back transactions are therefore spaced MEM_LAT+2 cycles apart.
- Requester rules:
  - A requester must drop its request in the cycle it sees done. If still high in the following IDLE cycle, it is treated as a new request.
  - Deasserting a request mid-transaction is ignored; the access completes and done still pulses.
  - Input changes after grant have no effect until the next IDLE.
- d_read and d_write both high at grant: the access executes as a write, err_rw is set, and err_rw stays set until reset.
- Reset mid-transaction: the access is abandoned and no done pulses. A memory write already strobed is not undone.

Test Plan:
- Single fetch, MEM_LAT=2: i_req=1, i_addr=0x40, memory returns 0x00A00093 -> mem_read high cycles 1-2, i_done in cycle 3, i_rdata=0x00A00093, d_done never pulses.
- Store: d_write=1, d_addr=0x100, d_wdata=0xDEAD -> mem_write high only in cycle 1 with mem_addr=0x100 and mem_wdata=0xDEAD, d_done in cycle 3, d_rdata unchanged.
- Tie after reset: i_req and d_read both held -> fetch served first (i_done cycle 3), load served next (granted cycle 4, d_done cycle 7), grant_data then 1. Both reasserted -> fetch wins again.
- Reset mid-access: reset asserted in cycle 2 of a load -> mem_read drops immediately, no d_done, state IDLE. A fresh i_req after release completes normally with first-tie priority back on fetch.
- Conflict: d_read=d_write=1 with d_addr=0x8 -> write strobe issued, err_rw=1 and stays set through subsequent clean transactions until reset.
- MEM_LAT=1 build: a load completes with d_done in cycle 2; a request held in IDLE two cycles after done starts a new transaction.
